clut_rle_dec: RTL and testbench
===============================

# clut_rle_dec

Parametrised run-length decoder for CLUT pixel streams between the display-file fetch unit and the CLUT lookup stage of a video plane. It supports three modes: RL7 (7-bit single-pixel runs), RL3 (3-bit pixel-pair runs) and passthrough. It also supports a programmable line length, end-of-line fill runs, a registered output stage and run-overrun detection. The line length and mode are latched per line, so one instance serves both planes and all display resolutions.

## Interface
Parameters:
- PIXEL_W, 8, width of source bytes and output pixels.
- COUNT_W, 11, width of the line pixel counter.
- MAX_LINE, 768, line length used when line_len is 0.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- mode  in  2  0 = passthrough, 1 = RL7, 2 = RL3, 3 = reserved (behaves as passthrough); latched at line start.
- line_len  in  COUNT_W  output pixels per line; latched at line start; 0 means MAX_LINE.
- src_pixel  in  PIXEL_W  source byte.
- src_write  in  1  source byte valid.
- src_strobe  out  1  source byte consumed this cycle; asserted only while src_write is high.
- dst_pixel  out  PIXEL_W  output pixel; upper bit is 0 in RL7, upper 5 bits are 0 in RL3.
- dst_write  out  1  output pixel valid (registered).
- dst_strobe  in  1  sink accepts the pixel this cycle when dst_write is high.
- line_done  out  1  one-cycle pulse when the last pixel of a line is accepted.
- overrun  out  1  sticky; set when a counted run exceeds the pixels remaining in the line; cleared by reset.

## Operation
- Output register: loads when it is empty or being accepted (dst_write & dst_strobe). It holds its value while dst_write=1 and dst_strobe=0. Source bytes are never consumed while a load is blocked.
- Line counter `remain`: loaded with the latched line length at line start. It decrements on each accepted pixel. When the accepted pixel makes `remain` 0, line_done pulses, the next line starts, and mode/line_len are re-latched.
- States: FETCH, COUNT, RUN, FILL, PAIR_B.
- FETCH:
  - Passthrough: the byte goes to the output unmodified.
  - RL7, bit7=0: emit {0,b[6:0]}.
  - RL7, bit7=1: store b[6:0] and go to COUNT.
  - RL3, bit7=0: emit b[6:4], store b[2:0] and go to PAIR_B.
  - RL3, bit7=1: store the pair and go to COUNT.
- PAIR_B: emit the stored B pixel, then return to FETCH. No source byte is consumed.
- COUNT: consume the count byte N.
  - N=0: go to FILL.
  - N≠0 in RL7: load run = N pixels and go to RUN.
  - N≠0 in RL3: load run = 2N pixels (A,B alternating, starting with A) and go to RUN.
- RUN: emit the stored pixel(s) and decrement run per emitted pixel. Return to FETCH when run reaches 0.
- FILL: emit the stored pixel (RL3: alternating A/B) until the line ends, then go to FETCH.
- Overrun: if the line ends while run > 0, set overrun, discard the rest of the run, and go to FETCH. The next line starts with a fresh byte.
- Any line end forces the state to FETCH, so a mid-pair RL3 byte at line end drops its B pixel.

## Timing
- Reset values: dst_write=0, dst_pixel=0, src_strobe=0, line_done=0, overrun=0. After reset, state=FETCH and remain=latched length from the current inputs.
- Latency is 1 cycle from the consumed source byte (or RUN step) to dst_write.
- Sustained throughput is 1 pixel/cycle while dst_strobe is held high and the source is valid.
- The COUNT byte produces no pixel. There is a one-cycle output bubble unless a prior pixel is still pending.
- src_strobe is combinational from state, the output-register load enable and src_write.
- A reset mid-run drops all pending pixels. dst_write is 0 on the next cycle.
- A mode change mid-line is ignored until line_done.

## Test plan
- RL7, line_len=4, bytes 0x05,0x06,0x07,0x08 with dst_strobe=1 -> pixels 5,6,7,8 on consecutive cycles; line_done on the 4th.
- RL7, line_len=8, bytes 0x83,0x03,0x81,0x00 -> 3,3,3,1,1,1,1,1; line_done on the 8th; overrun=0.
- RL3, line_len=6, bytes 0x25,0xB1,0x02 -> 2,5,3,1,3,1.
- RL7, line_len=4, bytes 0x82,0x06 -> 2,2,2,2; line_done; overrun=1. The next byte is decoded as a new-line FETCH.
- Backpressure: RL7 run 0x89,0x05 with dst_strobe toggling 1,0,0,1… -> exactly five 9s; dst_pixel is stable while stalled; no extra src_strobe.
- Passthrough, line_len=0 -> 768 bytes pass unmodified and line_done pulses once. Asserting reset mid-line -> dst_write=0 next cycle.

Source files
------------

// File: rtl/clut_rle_dec_if.sv
// Source/sink pixel handshake bundle shared by the fetch unit, the RLE decoder and the CLUT lookup.
// master = the fetch/lookup side that drives the stream and accepts pixels; slave = the decoder.
interface clut_rle_dec_if #(
    parameter int PIXEL_W = 8
);
    logic [PIXEL_W-1:0] src_pixel;
    logic               src_write;
    logic               src_strobe;
    logic [PIXEL_W-1:0] dst_pixel;
    logic               dst_write;
    logic               dst_strobe;

    modport master (
        output src_pixel, src_write, dst_strobe,
        input  src_strobe, dst_pixel, dst_write
    );

    modport slave (
        input  src_pixel, src_write, dst_strobe,
        output src_strobe, dst_pixel, dst_write
    );
endinterface

// File: rtl/clut_rle_dec.sv
// CLUT run-length decoder (passthrough / RL7 / RL3): one cycle source-to-registered-output latency.
// Output register holds under dst_strobe=0; no source byte is taken while it cannot load.
module clut_rle_dec #(
    parameter int PIXEL_W  = 8,
    parameter int COUNT_W  = 11,
    parameter int MAX_LINE = 768
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic [COUNT_W-1:0] line_len,
    clut_rle_dec_if.slave      bus,
    output logic               line_done,
    output logic               overrun
);
    localparam logic [2:0] FETCH  = 3'd0;
    localparam logic [2:0] COUNT  = 3'd1;
    localparam logic [2:0] RUN    = 3'd2;
    localparam logic [2:0] FILL   = 3'd3;
    localparam logic [2:0] PAIR_B = 3'd4;
    localparam int RUN_W = PIXEL_W + 1;

    logic [2:0]         state;
    logic [1:0]         lmode;
    logic [COUNT_W-1:0] remain;
    logic [COUNT_W-1:0] gen_rem;
    logic [RUN_W-1:0]   run;
    logic               phase;
    logic [PIXEL_W-1:0] pix_a;
    logic [PIXEL_W-1:0] pix_b;
    logic [PIXEL_W-1:0] out_pix;
    logic               out_vld;

    logic [PIXEL_W-1:0] src_byte;
    logic [PIXEL_W-1:0] lit7;
    logic [PIXEL_W-1:0] hi3;
    logic [PIXEL_W-1:0] lo3;
    logic [COUNT_W-1:0] len_eff;
    logic [1:0]         cur_mode;
    logic [COUNT_W-1:0] cur_gen;
    logic [2:0]         cur_state;
    logic               is_rl7;
    logic               is_rl3;
    logic               accept;
    logic               load_en;
    logic               step;

    logic               consume;
    logic               emit;
    logic               last_px;
    logic               set_ovr;
    logic [PIXEL_W-1:0] emit_pix;
    logic [2:0]         nxt_state;
    logic [RUN_W-1:0]   nxt_run;
    logic               nxt_phase;
    logic [PIXEL_W-1:0] nxt_a;
    logic [PIXEL_W-1:0] nxt_b;

    assign src_byte = bus.src_pixel;
    assign lit7     = PIXEL_W'(src_byte[6:0]);
    assign hi3      = PIXEL_W'(src_byte[6:4]);
    assign lo3      = PIXEL_W'(src_byte[2:0]);
    assign len_eff  = (line_len == '0) ? COUNT_W'(MAX_LINE) : line_len;

    assign accept    = out_vld & bus.dst_strobe;
    assign load_en   = ~out_vld | bus.dst_strobe;
    assign line_done = ~reset & accept & (remain == COUNT_W'(1));

    // The generator stops after producing a line's last pixel; it resumes in the cycle that pixel
    // is accepted, already using the freshly latched mode and length so no bubble is inserted.
    assign cur_mode  = line_done ? mode : lmode;
    assign cur_gen   = line_done ? len_eff : gen_rem;
    assign cur_state = line_done ? FETCH : state;
    assign is_rl7    = (cur_mode == 2'd1);
    assign is_rl3    = (cur_mode == 2'd2);
    assign step      = ~reset & load_en & (cur_gen != '0);

    always_comb begin
        consume   = 1'b0;
        emit      = 1'b0;
        emit_pix  = (is_rl3 && phase) ? pix_b : pix_a;
        nxt_state = cur_state;
        nxt_run   = run;
        nxt_phase = phase;
        nxt_a     = pix_a;
        nxt_b     = pix_b;
        case (cur_state)
            FETCH: begin
                if (bus.src_write) begin
                    consume = 1'b1;
                    if (is_rl7) begin
                        if (src_byte[7]) begin
                            nxt_a     = lit7;
                            nxt_state = COUNT;
                        end else begin
                            emit     = 1'b1;
                            emit_pix = lit7;
                        end
                    end else if (is_rl3) begin
                        nxt_b = lo3;
                        if (src_byte[7]) begin
                            nxt_a     = hi3;
                            nxt_state = COUNT;
                        end else begin
                            emit      = 1'b1;
                            emit_pix  = hi3;
                            nxt_state = PAIR_B;
                        end
                    end else begin
                        emit     = 1'b1;
                        emit_pix = src_byte;
                    end
                end
            end
            COUNT: begin
                if (bus.src_write) begin
                    consume   = 1'b1;
                    nxt_phase = 1'b0;
                    if (src_byte == '0) begin
                        nxt_state = FILL;
                    end else begin
                        nxt_run   = is_rl3 ? {src_byte, 1'b0} : {1'b0, src_byte};
                        nxt_state = RUN;
                    end
                end
            end
            RUN: begin
                emit      = 1'b1;
                nxt_run   = run - RUN_W'(1);
                nxt_phase = is_rl3 & ~phase;
                if (nxt_run == '0) begin
                    nxt_state = FETCH;
                end
            end
            FILL: begin
                emit      = 1'b1;
                nxt_phase = is_rl3 & ~phase;
            end
            PAIR_B: begin
                emit      = 1'b1;
                emit_pix  = pix_b;
                nxt_state = FETCH;
            end
            default: begin
                nxt_state = FETCH;
            end
        endcase
        // Line end wins over everything: a pending B pixel or run remainder is dropped.
        last_px = emit && (cur_gen == COUNT_W'(1));
        set_ovr = last_px && (cur_state == RUN) && (nxt_run != '0);
        if (last_px) begin
            nxt_state = FETCH;
        end
    end

    assign bus.src_strobe = step & consume;
    assign bus.dst_write  = out_vld;
    assign bus.dst_pixel  = out_pix;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= FETCH;
            lmode   <= mode;
            remain  <= len_eff;
            gen_rem <= len_eff;
            run     <= '0;
            phase   <= 1'b0;
            pix_a   <= '0;
            pix_b   <= '0;
            out_pix <= '0;
            out_vld <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (line_done) begin
                lmode  <= mode;
                remain <= len_eff;
                state  <= FETCH;
            end else if (accept) begin
                remain <= remain - COUNT_W'(1);
            end

            if (step) begin
                state <= nxt_state;
                run   <= nxt_run;
                phase <= nxt_phase;
                pix_a <= nxt_a;
                pix_b <= nxt_b;
            end

            if (step && emit) begin
                gen_rem <= cur_gen - COUNT_W'(1);
            end else if (line_done) begin
                gen_rem <= len_eff;
            end

            if (load_en) begin
                out_vld <= step & emit;
                if (step && emit) begin
                    out_pix <= emit_pix;
                end
            end

            if (step && set_ovr) begin
                overrun <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_clut_rle_dec.sv
// Bench for clut_rle_dec: fixed decode vectors, hand-built corner sequences and a randomized
// stream compared against a byte-level decode model.
`timescale 1ns/1ps
module tb_clut_rle_dec;
    localparam int PW = 8;
    localparam int CW = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [CW-1:0] line_len = '0;
    logic          line_done;
    logic          overrun;

    clut_rle_dec_if #(.PIXEL_W(PW)) bus();

    clut_rle_dec #(.PIXEL_W(PW), .COUNT_W(CW), .MAX_LINE(768)) dut (
        .clk       (clk),
        .reset     (reset),
        .mode      (mode),
        .line_len  (line_len),
        .bus       (bus),
        .line_done (line_done),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          md;
        int          len;
        int          nb;
        logic [63:0] bytes;
        int          np;
        logic [63:0] pix;
        int          lines;
        bit          ovr;
    } vec_t;

    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  src_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    int          got_cyc[$];
    int          exp_lines;
    bit          exp_ovr;
    int          strobes;
    int          lines_seen;
    vec_t        vecs[10];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset(input int md, input int len);
        mode = md[1:0];
        line_len = len[CW-1:0];
        reset = 1'b1;
        bus.src_write = 1'b0;
        bus.src_pixel = '0;
        bus.dst_strobe = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    // Decode the whole byte queue from the format rules, cutting lines at the line length.
    task automatic build_expected(input int md, input int len);
        int L, rem, i, n, cnt;
        logic [7:0] b, a, bb;
        logic [7:0] seq[$];
        bit counted;
        L = (len == 0) ? 768 : len;
        rem = L;
        i = 0;
        exp_q.delete();
        exp_lines = 0;
        exp_ovr = 0;
        while (i < src_q.size()) begin
            b = src_q[i];
            i++;
            seq.delete();
            counted = 0;
            if ((md == 1 || md == 2) && b[7]) begin
                if (i >= src_q.size()) break;
                n = int'(src_q[i]);
                i++;
                a  = (md == 1) ? {1'b0, b[6:0]} : {5'b0, b[6:4]};
                bb = (md == 1) ? a : {5'b0, b[2:0]};
                cnt = (n == 0) ? rem : ((md == 1) ? n : 2 * n);
                counted = (n != 0);
                for (int k = 0; k < cnt; k++) seq.push_back((k % 2 == 1) ? bb : a);
            end else if (md == 1) begin
                seq.push_back({1'b0, b[6:0]});
            end else if (md == 2) begin
                seq.push_back({5'b0, b[6:4]});
                seq.push_back({5'b0, b[2:0]});
            end else begin
                seq.push_back(b);
            end
            for (int k = 0; k < seq.size(); k++) begin
                exp_q.push_back(seq[k]);
                rem--;
                if (rem == 0) begin
                    exp_lines++;
                    rem = L;
                    if (counted && k + 1 < seq.size()) exp_ovr = 1;
                    break;
                end
            end
        end
    endtask

    task automatic run_stream(input string name, input int len, input int stall_pct,
                              input int gap_pct, input bit pattern);
        int idx, cyc, idle, L, nmin;
        bit prev_stall;
        logic [7:0] prev_pix;
        idx = 0; cyc = 0; idle = 0;
        L = (len == 0) ? 768 : len;
        prev_stall = 0;
        prev_pix = '0;
        got_q.delete();
        got_cyc.delete();
        strobes = 0;
        lines_seen = 0;
        while (cyc < 20000 && idle < 20) begin
            bus.src_write = (idx < src_q.size()) && ($urandom_range(99) >= gap_pct);
            if (idx < src_q.size()) bus.src_pixel = src_q[idx];
            else bus.src_pixel = 8'h00;
            if (pattern) bus.dst_strobe = (cyc % 4 == 0) || (cyc % 4 == 3);
            else bus.dst_strobe = ($urandom_range(99) >= stall_pct);
            @(negedge clk);
            if (bus.src_strobe && !bus.src_write) check({name, "/strobe_no_write"}, 1, 0);
            if (prev_stall) check({name, "/hold"}, {bus.dst_write, bus.dst_pixel}, {1'b1, prev_pix});
            prev_stall = bus.dst_write && !bus.dst_strobe;
            prev_pix = bus.dst_pixel;
            if (bus.src_write && bus.src_strobe) begin
                idx++;
                strobes++;
            end
            if (bus.dst_write && bus.dst_strobe) begin
                got_q.push_back(bus.dst_pixel);
                got_cyc.push_back(cyc);
                check({name, "/line_done"}, int'(line_done), int'((got_q.size() % L) == 0));
                if (line_done) lines_seen++;
            end else if (line_done) begin
                check({name, "/line_done_idle"}, 1, 0);
            end
            if (idx >= src_q.size() && got_q.size() >= exp_q.size()) idle++;
            cyc++;
            @(posedge clk); #1;
        end
        bus.src_write = 1'b0;
        bus.dst_strobe = 1'b0;
        if (cyc >= 20000) check({name, "/timeout"}, 1, 0);
        check({name, "/count"}, got_q.size(), exp_q.size());
        nmin = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < nmin; i++) check({name, "/pix"}, int'(got_q[i]), int'(exp_q[i]));
        check({name, "/lines"}, lines_seen, exp_lines);
        check({name, "/overrun"}, int'(overrun), int'(exp_ovr));
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t v;
        int md, len;
        bus.src_write = 1'b0;
        bus.src_pixel = '0;
        bus.dst_strobe = 1'b0;

        vecs[0] = '{1, 4, 4, 64'h08_07_06_05, 4, 64'h08_07_06_05, 1, 1'b0};
        vecs[1] = '{1, 8, 4, 64'h00_81_03_83, 8, 64'h01_01_01_01_01_03_03_03, 1, 1'b0};
        vecs[2] = '{2, 6, 3, 64'h02_B1_25, 6, 64'h01_03_01_03_05_02, 1, 1'b0};
        vecs[3] = '{1, 4, 3, 64'h05_06_82, 5, 64'h05_02_02_02_02, 1, 1'b1};
        vecs[4] = '{0, 3, 3, 64'h01_80_FF, 3, 64'h01_80_FF, 1, 1'b0};
        vecs[5] = '{2, 5, 4, 64'h11_37_25_25, 7, 64'h01_01_03_05_02_05_02, 1, 1'b0};
        vecs[6] = '{2, 5, 2, 64'h00_B2, 5, 64'h03_02_03_02_03, 1, 1'b0};
        vecs[7] = '{3, 2, 2, 64'h9A_85, 2, 64'h9A_85, 1, 1'b0};
        vecs[8] = '{2, 4, 2, 64'h02_A1, 4, 64'h01_02_01_02, 1, 1'b0};
        vecs[9] = '{2, 3, 2, 64'h02_A1, 3, 64'h02_01_02, 1, 1'b1};

        // Reset values, with a source byte offered during reset.
        mode = 2'd1;
        line_len = 11'd4;
        reset = 1'b1;
        bus.src_write = 1'b1;
        bus.src_pixel = 8'h05;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst/dst_write", int'(bus.dst_write), 0);
        check("rst/dst_pixel", int'(bus.dst_pixel), 0);
        check("rst/src_strobe", int'(bus.src_strobe), 0);
        check("rst/line_done", int'(line_done), 0);
        check("rst/overrun", int'(overrun), 0);

        for (int t = 0; t < 10; t++) begin
            v = vecs[t];
            do_reset(v.md, v.len);
            src_q.delete();
            exp_q.delete();
            for (int i = 0; i < v.nb; i++) src_q.push_back(v.bytes[8*i +: 8]);
            for (int i = 0; i < v.np; i++) exp_q.push_back(v.pix[8*i +: 8]);
            exp_lines = v.lines;
            exp_ovr = v.ovr;
            run_stream($sformatf("vec%0d", t), v.len, 0, 0, 1'b0);
            if (t == 0 && got_cyc.size() == 4) check("vec0/consecutive", got_cyc[3] - got_cyc[0], 3);
        end

        // Backpressure on a counted run: five 9s, two source bytes taken.
        do_reset(1, 8);
        src_q = '{8'h89, 8'h05};
        exp_q = '{8'h09, 8'h09, 8'h09, 8'h09, 8'h09};
        exp_lines = 0;
        exp_ovr = 0;
        run_stream("bp", 8, 0, 0, 1'b1);
        check("bp/strobes", strobes, 2);

        // Full-length passthrough line with line_len = 0.
        do_reset(0, 0);
        src_q.delete();
        for (int i = 0; i < 770; i++) src_q.push_back(8'($urandom_range(255)));
        build_expected(0, 0);
        run_stream("pt768", 0, 20, 10, 1'b0);
        check("pt768/one_line", lines_seen, 1);

        // Reset with a fill pixel pending in the output register.
        do_reset(1, 16);
        bus.dst_strobe = 1'b0;
        bus.src_write = 1'b1;
        bus.src_pixel = 8'h81;
        @(posedge clk); #1;
        bus.src_pixel = 8'h00;
        @(posedge clk); #1;
        bus.src_write = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst/pending", int'(bus.dst_write), 1);
        @(posedge clk); #1;
        line_len = 11'd2;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst/dst_write", int'(bus.dst_write), 0);
        reset = 1'b0;
        @(posedge clk); #1;
        src_q = '{8'h07, 8'h08};
        exp_q = '{8'h07, 8'h08};
        exp_lines = 1;
        exp_ovr = 0;
        run_stream("midrst/after", 2, 0, 0, 1'b0);

        // Randomized streams against the decode model.
        for (int r = 0; r < 16; r++) begin
            md = $urandom_range(3);
            len = $urandom_range(1, 16);
            do_reset(md, len);
            src_q.delete();
            for (int i = 0; i < 24; i++)
                src_q.push_back(8'($urandom_range(255)) & ((r % 2 == 1) ? 8'hFF : 8'h87));
            build_expected(md, len);
            run_stream($sformatf("rnd%0d_m%0d_l%0d", r, md, len), len,
                       $urandom_range(60), $urandom_range(50), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
